// File: rtl/row_window_buffer.sv
// Three-row sliding window over a pixel stream, fed to convg8.
// Two line memories hold the previous lines; one output register stage.
module row_window_buffer #(
  parameter int PIXEL_WIDTH     = 8,
  parameter int PIXELS_PER_WORD = 16,
  parameter int IMAGE_WIDTH     = 512,
  parameter int IMAGE_HEIGHT    = 512
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] s_axis_tdata,
  input  logic                                   s_axis_tvalid,
  input  logic                                   s_axis_tlast,
  output logic                                   s_axis_tready,
  output logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] m_row_top,
  output logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] m_row_mid,
  output logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] m_row_bot,
  output logic                                   m_sol,
  output logic                                   m_eol,
  output logic                                   m_tlast,
  output logic                                   m_tvalid,
  input  logic                                   m_tready,
  output logic [15:0]                            frame_cnt,
  output logic                                   tlast_err
);

  localparam int WORD_WIDTH     = PIXEL_WIDTH * PIXELS_PER_WORD;
  localparam int BEATS_PER_LINE = IMAGE_WIDTH / PIXELS_PER_WORD;
  localparam int CW = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;
  localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

  logic [WORD_WIDTH-1:0] r_lb0 [BEATS_PER_LINE];
  logic [WORD_WIDTH-1:0] r_lb1 [BEATS_PER_LINE];
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;

  logic                  w_acc;
  logic                  w_col_end;
  logic                  w_last_pos;
  logic                  w_frame_end;
  logic                  w_emit;
  logic [WORD_WIDTH-1:0] w_top;
  logic [WORD_WIDTH-1:0] w_mid;

  assign s_axis_tready = ~m_tvalid | m_tready;
  assign w_acc         = s_axis_tvalid & s_axis_tready;
  assign w_col_end     = (r_col == CW'(BEATS_PER_LINE - 1));
  assign w_last_pos    = w_col_end & (r_row == RW'(IMAGE_HEIGHT - 1));
  assign w_frame_end   = w_last_pos | s_axis_tlast;
  assign w_emit        = w_acc & (r_row >= RW'(2));
  assign w_top         = r_lb0[r_col];
  assign w_mid         = r_lb1[r_col];

  // Line memories shift one line down per accepted beat; never reset.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lb0[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= s_axis_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col     <= '0;
      r_row     <= '0;
      frame_cnt <= '0;
      tlast_err <= 1'b0;
    end else if (w_acc) begin
      if (w_frame_end) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_col_end) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
      if (w_frame_end)
        frame_cnt <= frame_cnt + 16'd1;
      if (s_axis_tlast != w_last_pos)
        tlast_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_row_top <= '0;
      m_row_mid <= '0;
      m_row_bot <= '0;
      m_sol     <= 1'b0;
      m_eol     <= 1'b0;
      m_tlast   <= 1'b0;
      m_tvalid  <= 1'b0;
    end else if (w_emit) begin
      m_row_top <= w_top;
      m_row_mid <= w_mid;
      m_row_bot <= s_axis_tdata;
      m_sol     <= (r_col == '0);
      m_eol     <= w_col_end;
      m_tlast   <= w_frame_end;
      m_tvalid  <= 1'b1;
    end else begin
      m_tvalid  <= m_tvalid & ~m_tready;
    end
  end

endmodule

// File: tb/tb_row_window_buffer.sv
// Bench for row_window_buffer at 64x4 with a frame-array reference model.
// Random handshakes plus directed tlast, stall and reset scenarios.
module tb_row_window_buffer;

  localparam int IW  = 64;
  localparam int IH  = 4;
  localparam int WW  = 128;
  localparam int BPL = IW / 16;
  localparam int WB  = 3 * WW + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [WW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic [WW-1:0] m_row_top;
  logic [WW-1:0] m_row_mid;
  logic [WW-1:0] m_row_bot;
  logic          m_sol;
  logic          m_eol;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic [15:0]   frame_cnt;
  logic          tlast_err;

  row_window_buffer #(
    .PIXEL_WIDTH(8), .PIXELS_PER_WORD(16),
    .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_row_top(m_row_top), .m_row_mid(m_row_mid),
    .m_row_bot(m_row_bot), .m_sol(m_sol), .m_eol(m_eol),
    .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .frame_cnt(frame_cnt), .tlast_err(tlast_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [WB-1:0] q[$];
  logic [WW-1:0] line_m [IH][BPL];
  int            mk;
  int            acc_cnt;
  int            win_cnt;
  logic [WB-1:0] first_win;
  logic [WB-1:0] last_win;
  logic [WB-1:0] held;

  int vpct = 100;
  int rpct = 100;
  bit stall_en = 0;
  bit tv_chk = 0;
  int stall_left = 0;

  task automatic check(input string tag,
                       input logic [399:0] obs,
                       input logic [399:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [WB-1:0] obs_win();
    return {m_row_top, m_row_mid, m_row_bot, m_sol, m_eol, m_tlast};
  endfunction

  function automatic logic [WW-1:0] fill(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic model_reset();
    q.delete();
    mk = 0;
    acc_cnt = 0;
    win_cnt = 0;
  endtask

  // Frame-position model: beat index k within the frame gives (r, c).
  task automatic model_accept(input logic [WW-1:0] d, input logic tl);
    int r;
    int c;
    bit fend;
    r = mk / BPL;
    c = mk % BPL;
    fend = tl || (mk == IH * BPL - 1);
    if (r >= 2)
      q.push_back({line_m[r-2][c], line_m[r-1][c], d,
                   c == 0, c == BPL - 1, fend});
    line_m[r][c] = d;
    mk = fend ? 0 : mk + 1;
    acc_cnt++;
  endtask

  task automatic pop_check();
    logic [WB-1:0] e;
    check("win_pending", q.size() > 0, 1);
    if (q.size() > 0) begin
      e = q.pop_front();
      check("window", obs_win(), e);
    end
    if (win_cnt == 0) first_win = obs_win();
    last_win = obs_win();
    win_cnt++;
  endtask

  task automatic tick(output bit acc);
    acc = s_axis_tvalid && s_axis_tready;
    if (m_tvalid && m_tready) pop_check();
    if (acc) model_accept(s_axis_tdata, s_axis_tlast);
    @(negedge clk);
    cyc++;
    if (cyc > 60000) begin
      $display("FAIL timeout cycles=%0d", cyc);
      $fatal(1);
    end
  endtask

  task automatic send_frame(input int nbeats, input int tlast_at,
                            input bit rnd);
    bit acc;
    bit stall;
    for (int b = 0; b < nbeats; b++) begin
      acc = 0;
      if (rnd)
        s_axis_tdata = {$urandom, $urandom, $urandom, $urandom};
      else
        s_axis_tdata = fill(8'(8'h10 + b / BPL));
      s_axis_tlast = (b == tlast_at);
      while (!acc) begin
        s_axis_tvalid = ($urandom_range(99) < vpct);
        m_tready = ($urandom_range(99) < rpct);
        stall = stall_en && win_cnt == 2 && m_tvalid && stall_left > 0;
        if (stall) m_tready = 1'b0;
        #1;
        if (tv_chk) check("tvalid_latency", m_tvalid, acc_cnt >= 9);
        if (stall) begin
          if (stall_left == 5) held = obs_win();
          else check("stall_hold", obs_win(), held);
          check("stall_tready", s_axis_tready, 0);
          stall_left--;
        end
        tick(acc);
      end
    end
  endtask

  task automatic drain();
    bit a;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    for (int i = 0; i < 20 && (q.size() > 0 || m_tvalid); i++) begin
      m_tready = 1'b1;
      #1;
      tick(a);
    end
    check("drain_empty", q.size(), 0);
    check("drain_tvalid", m_tvalid, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tdata = '0;
    m_tready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    do_reset();
    #1;
    check("rst_flags", {m_tvalid, m_sol, m_eol, m_tlast, tlast_err}, 0);
    check("rst_fcnt", frame_cnt, 0);
    check("rst_rows", {m_row_top, m_row_mid, m_row_bot}, 0);

    // Clean frame, always valid/ready
    tv_chk = 1;
    send_frame(16, 15, 0);
    tv_chk = 0;
    drain();
    check("t1_wins", win_cnt, 8);
    check("t1_fcnt", frame_cnt, 1);
    check("t1_err", tlast_err, 0);
    check("t1_first", first_win,
          {fill(8'h10), fill(8'h11), fill(8'h12), 3'b100});
    check("t1_last", last_win,
          {fill(8'h11), fill(8'h12), fill(8'h13), 3'b011});

    // Output stall on window 2
    do_reset();
    stall_en = 1;
    stall_left = 5;
    send_frame(16, 15, 0);
    drain();
    stall_en = 0;
    check("t2_stall_done", stall_left, 0);
    check("t2_wins", win_cnt, 8);
    check("t2_fcnt", frame_cnt, 1);

    // Random data and handshakes, back-to-back frames
    do_reset();
    vpct = 70;
    rpct = 60;
    for (int f = 0; f < 10; f++) send_frame(16, 15, 1);
    drain();
    vpct = 100;
    rpct = 100;
    check("t3_wins", win_cnt, 80);
    check("t3_fcnt", frame_cnt, 10);
    check("t3_err", tlast_err, 0);

    // Early tlast on beat 9, then one beat of the next frame
    do_reset();
    send_frame(10, 9, 0);
    send_frame(1, -1, 0);
    drain();
    check("t4_err", tlast_err, 1);
    check("t4_fcnt", frame_cnt, 1);
    check("t4_wins", win_cnt, 2);
    check("t4_last", last_win,
          {fill(8'h10), fill(8'h11), fill(8'h12), 3'b001});

    // Missing tlast
    do_reset();
    send_frame(16, -1, 0);
    drain();
    check("t5_err", tlast_err, 1);
    check("t5_fcnt", frame_cnt, 1);
    check("t5_wins", win_cnt, 8);
    check("t5_flags", last_win[2:0], 3'b011);

    // Reset pulse mid-frame, then a clean frame
    do_reset();
    send_frame(11, -1, 0);
    s_axis_tvalid = 1'b0;
    m_tready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_tvalid", m_tvalid, 0);
    check("t6_fcnt", frame_cnt, 0);
    model_reset();
    send_frame(16, 15, 0);
    drain();
    check("t6_wins", win_cnt, 8);
    check("t6_fcnt2", frame_cnt, 1);
    check("t6_err", tlast_err, 0);
    check("t6_last", last_win,
          {fill(8'h11), fill(8'h12), fill(8'h13), 3'b011});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
